// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory command interface and the memory-side
// responder:
//   mem_cmd_t     command encoding on mem_cmd (2'b11 is reserved, acts as NONE)
//   resp_state_t  responder FSM states
//   MMIO_*_ADDR   word addresses of the switch input and LED register
//   CNT_W         width of the read wait-state counter (RD_LAT up to 8)
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_ACK
  } resp_state_t;

  localparam int unsigned MMIO_SW_ADDR  = 32'h140;
  localparam int unsigned MMIO_LED_ADDR = 32'h100;

  // Holds RD_LAT-2, i.e. at most 6.
  localparam int CNT_W = 3;

endpackage

// File: rtl/ram_1rw.sv
// -----------------------------------------------------------------------------
// ram_1rw
// Synchronous single-port RAM with a registered read port. The read register
// only updates on a read access (en=1, we=0), so it holds its value across
// writes and idle cycles.
// Ports:
//   clk    clock
//   en     access enable
//   we     write enable (qualified by en)
//   addr   word address
//   wdata  write data
//   rdata  registered read data
// -----------------------------------------------------------------------------
module ram_1rw #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // NOTE: the array and its read register carry no reset; a reset term would
  // stop the array mapping onto a RAM macro and its contents are undefined
  // after power-up anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side end of the mem_cmd/mem_addr bus. Accepts READ/WRITE commands in
// IDLE, services them from an internal RAM (lower half of the address space)
// or optional memory-mapped I/O, and returns read data RD_LAT cycles after
// the accept edge. Commands arriving while busy are ignored; a command held
// on mem_cmd is re-accepted each time the FSM is back in IDLE.
//
// Build option: define MEM_RESPONDER_MMIO_EN to map the switch inputs at
// MMIO_SW_ADDR (read-only) and an 8-bit LED register at MMIO_LED_ADDR.
// Without it, ledr is tied low, sw is ignored and the upper half is unmapped.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-low reset
//   mem_cmd     00 NONE, 01 READ, 10 WRITE, 11 treated as NONE
//   mem_addr    word address, sampled at accept
//   write_data  write data, sampled at accept
//   read_data   read result, holds between reads
//   read_valid  one-cycle pulse, read_data valid
//   write_ack   one-cycle pulse, write retired
//   busy        command in flight (state != IDLE)
//   err         pulses with read_valid/write_ack for an unmapped address
//   sw          switch inputs
//   ledr        LED register
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              write_ack,
  output logic              busy,
  output logic              err,
  input  logic [7:0]        sw,
  output logic [7:0]        ledr
);

  resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mmio_rdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              sel_ram_q;
  logic              err_q, err_d;
  logic              is_read, is_write;
  logic              load, ram_we, ram_en, led_we;
  logic              hit_ram, hit_sw, hit_led, hit_any;
  logic [7:0]        ledr_q;

  // Reserved 2'b11 matches neither and is therefore ignored like NONE.
  assign is_read  = (mem_cmd == MEM_READ);
  assign is_write = (mem_cmd == MEM_WRITE);

  // In IDLE the live bus address is decoded (accept edge); once a read is in
  // flight the latched address is used, so bus changes cannot disturb it.
  assign ld_addr = (state_q == ST_IDLE) ? mem_addr : addr_q;

  assign hit_ram = ~ld_addr[ADDR_W-1];
`ifdef MEM_RESPONDER_MMIO_EN
  assign hit_sw  = (ld_addr == ADDR_W'(MMIO_SW_ADDR));
  assign hit_led = (ld_addr == ADDR_W'(MMIO_LED_ADDR));
`else
  assign hit_sw  = 1'b0;
  assign hit_led = 1'b0;
`endif
  assign hit_any = hit_ram | hit_sw | hit_led;

  // Next-state / control decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    ram_we  = 1'b0;
    led_we  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_read) begin
          if (RD_LAT == 1) begin
            state_d = ST_RD_RESP;
            load    = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_W'(RD_LAT - 2);
          end
        end else if (is_write) begin
          // The write commits at the accept edge; WR_ACK only reports it.
          state_d = ST_WR_ACK;
          ram_we  = hit_ram;
          led_we  = hit_led;
          err_d   = ~hit_any;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_RESP: state_d = ST_IDLE;
      ST_WR_ACK:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // err is registered on the edge entering RD_RESP/WR_ACK, so it is high
    // for exactly the cycle of the matching pulse.
    if (load) err_d = ~hit_any;
  end

  // The RAM is read on the edge that enters RD_RESP, not at accept, so its
  // output register changes only when read_data is meant to change.
  assign ram_en = ram_we | (load & hit_ram);

  ram_1rw #(
    .AW(ADDR_W - 1),
    .DW(DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ld_addr[ADDR_W-2:0]),
    .wdata(write_data),
    .rdata(ram_rdata)
  );

  // Non-RAM read value; zero for RAM hits and unmapped addresses.
  always_comb begin
    mmio_rdata = '0;
`ifdef MEM_RESPONDER_MMIO_EN
    if (hit_sw)  mmio_rdata = DATA_W'(sw);
    if (hit_led) mmio_rdata = DATA_W'(ledr_q);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      sel_ram_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && is_read) addr_q <= mem_addr;
      if (load) begin
        sel_ram_q <= hit_ram;
        rd_q      <= mmio_rdata;
      end
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ledr_q <= '0;
    else if (led_we) ledr_q <= write_data[7:0];
  end
`else
  logic unused_sw;
  assign ledr_q    = '0;
  assign unused_sw = ^{sw, led_we};
`endif

  // read_data is a select between two registers that both update only on the
  // edge entering RD_RESP (RAM output register or MMIO/zero holding register);
  // the select resets low so read_data reads 0 out of reset.
  assign read_data  = sel_ram_q ? ram_rdata : rd_q;
  assign read_valid = (state_q == ST_RD_RESP);
  assign write_ack  = (state_q == ST_WR_ACK);
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;
  assign ledr       = ledr_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's `mem_cmd`/`mem_addr` bus. It accepts NONE/READ/WRITE commands from the controller FSM, services them against an internal single-port RAM (and optional memory-mapped switch/LED I/O), and returns read data with a programmable wait-state latency. It sits between the controller/datapath and on-chip memory, at the opposite end of the memory command interface.

## Interface
- `ADDR_W`, 9: word address width; RAM occupies addresses with `mem_addr[ADDR_W-1]==0` (256 words at default).
- `DATA_W`, 16: data word width.
- `RD_LAT`, 2: read latency in cycles, legal range 1..8.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_cmd`  in  2  00 NONE, 01 READ, 10 WRITE, 11 reserved (treated as NONE).
- `mem_addr`  in  ADDR_W  word address, sampled at accept.
- `write_data`  in  DATA_W  write data, sampled at accept.
- `read_data`  out  DATA_W  read result; holds last value between reads.
- `read_valid`  out  1  one-cycle pulse, `read_data` valid.
- `write_ack`  out  1  one-cycle pulse, write retired.
- `busy`  out  1  high while a command is in flight; commands ignored.
- `err`  out  1  pulses with `read_valid`/`write_ack` when the address decoded to nothing.
- `sw`  in  8  switch inputs (MMIO build only).
- `ledr`  out  8  LED register (MMIO build only).

## Operation
- States: IDLE, RD_WAIT, RD_RESP, WR_ACK.
- IDLE: `mem_cmd`==READ -> latch addr; go RD_RESP if `RD_LAT`==1 else RD_WAIT with `cnt`=`RD_LAT`-2. WRITE -> perform write at the accept edge, go WR_ACK. NONE/11 -> stay.
- RD_WAIT: `cnt`==0 -> load `read_data`, go RD_RESP; else decrement `cnt`.
- RD_RESP: `read_valid`=1 for this cycle; next state IDLE unconditionally.
- WR_ACK: `write_ack`=1 for this cycle; next state IDLE.
- Decode: `mem_addr[ADDR_W-1]==0` -> RAM[`mem_addr[ADDR_W-2:0]`]. Else MMIO if enabled, otherwise unmapped.
- Unmapped read: `read_data`=0, `err`=1 in RD_RESP. Unmapped write: dropped, `err`=1 in WR_ACK.
- `mem_cmd` held constant by the initiator is re-accepted every time the FSM returns to IDLE. This is the required behaviour; the initiator drops to NONE to stop.
- `mem_cmd`, `mem_addr`, and `write_data` changes while `busy` have no effect on the in-flight command.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, `read_data`=0, `read_valid`=0, `write_ack`=0, `busy`=0, `err`=0, `ledr`=0, `cnt`=0. RAM contents are not reset.
- Reset asserted mid-command aborts it. No pulse is emitted, and a write already committed at its accept edge stays committed.
- Read: accept edge E. `read_valid` is high during cycle E+`RD_LAT` (after edge E+`RD_LAT`-1... i.e. exactly `RD_LAT` cycles after accept). Occupancy is `RD_LAT`+1 cycles. Earliest next accept is at the edge ending RD_RESP.
- Write: RAM updated at edge E. `write_ack` is high in the following cycle. Occupancy is 2 cycles.
- `busy` = state != IDLE (Moore, registered-state decode).
- `read_data` is registered and changes only at the edge entering RD_RESP.

## Configuration
- `MEM_RESPONDER_MMIO_EN` defined: address 0x140 reads `{8'b0, sw}`, and address 0x100 write loads `ledr` <= `write_data[7:0]` (read of 0x100 returns `{8'b0, ledr}`). Other upper-half addresses are unmapped.
- Undefined: `sw`/`ledr` ports are still present, `ledr` is tied 0, `sw` is ignored, and all upper-half addresses are unmapped.

## Structure
- Shared package `mem_pkg`: `mem_cmd_t` enum (`MEM_NONE`, `MEM_READ`, `MEM_WRITE`), MMIO address constants `MMIO_SW_ADDR`, `MMIO_LED_ADDR`, and responder state enum.
- One sub-module `ram_1rw`: synchronous single-port RAM (`ADDR_W`-1 address bits, `DATA_W` data bits, write-enable, registered read). The FSM, wait counter, decode, and MMIO registers live in `mem_responder`.

## Test plan
- Reset, then WRITE addr 0x005 data 0xBEEF, then READ 0x005 with `RD_LAT`=2 -> `write_ack` one cycle after the write accept; `read_valid` 2 cycles after the read accept with `read_data`=0xBEEF, `err`=0.
- `RD_LAT`=1 and `RD_LAT`=8 builds, READ held for 3 commands -> `read_valid` pulses spaced `RD_LAT`+1 cycles apart; `busy` low exactly one cycle between pulses.
- MMIO build: `sw`=0xA5, READ 0x140 -> `read_data`=0x00A5. WRITE 0x100 data 0x123C -> `ledr`=0x3C.
- Non-MMIO build: WRITE 0x100 then READ 0x100 -> `err`=1 on both; `read_data`=0; `ledr`=0.
- During RD_WAIT, change `mem_addr`/`mem_cmd` to WRITE -> original read completes unchanged and no write occurs.
- Assert `reset` low mid-RD_WAIT -> outputs zero immediately (asynchronously); no `read_valid` after release; next READ works normally.
